// File: rtl/cpu_io_port.sv
// CPU byte I/O endpoint: host-fed input FIFO served on CPU read edges, and an output
// FIFO filled on CPU write edges and drained by the host over valid/ready.
module cpu_io_port #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] cpu_in,
  input  logic              cpu_in_en,
  input  logic [DATA_W-1:0] cpu_out,
  input  logic              cpu_out_en,
  input  logic [DATA_W-1:0] host_in_data,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  output logic [DATA_W-1:0] host_out_data,
  output logic              host_out_valid,
  input  logic              host_out_ready,
  output logic [CNT_W-1:0]  in_count,
  output logic [CNT_W-1:0]  out_count,
  output logic              in_underflow,
  output logic              out_overflow,
  input  logic              clear_flags,
  output logic [DATA_W-1:0] last_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_in_mem  [DEPTH];
  logic [DATA_W-1:0] r_out_mem [DEPTH];
  logic [PTR_W-1:0]  r_in_wp, r_in_rp, r_out_wp, r_out_rp;
  logic [CNT_W-1:0]  r_in_cnt, r_out_cnt;
  logic              r_in_en_d, r_out_en_d;
  logic [DATA_W-1:0] r_cpu_in, r_last_out;
  logic              r_in_uf, r_out_of;

  logic w_rd_edge, w_wr_edge;
  logic w_in_full, w_in_empty, w_out_full, w_out_empty;
  logic w_in_push, w_in_pop, w_out_push, w_out_pop;

  // All full/empty decisions come from registered state only, so a full FIFO
  // refuses a push even when a pop happens in the same cycle.
  assign w_rd_edge   = cpu_in_en  & ~r_in_en_d;
  assign w_wr_edge   = cpu_out_en & ~r_out_en_d;
  assign w_in_full   = (r_in_cnt  == FULL_CNT);
  assign w_in_empty  = (r_in_cnt  == '0);
  assign w_out_full  = (r_out_cnt == FULL_CNT);
  assign w_out_empty = (r_out_cnt == '0);
  assign w_in_push   = host_in_valid & ~w_in_full;
  assign w_in_pop    = w_rd_edge & ~w_in_empty;
  assign w_out_push  = w_wr_edge & ~w_out_full;
  assign w_out_pop   = host_out_ready & ~w_out_empty;

  always_ff @(posedge clk) begin
    if (w_in_push)  r_in_mem[r_in_wp]   <= host_in_data;
    if (w_out_push) r_out_mem[r_out_wp] <= cpu_out;
  end

  // History registers reset high so a strobe held across reset release is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_en_d  <= 1'b1;
      r_out_en_d <= 1'b1;
      r_in_wp    <= '0;
      r_in_rp    <= '0;
      r_out_wp   <= '0;
      r_out_rp   <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_cpu_in   <= '0;
      r_last_out <= '0;
      r_in_uf    <= 1'b0;
      r_out_of   <= 1'b0;
    end else begin
      r_in_en_d  <= cpu_in_en;
      r_out_en_d <= cpu_out_en;

      if (w_in_push)  r_in_wp  <= r_in_wp + PTR_W'(1);
      if (w_in_pop)   r_in_rp  <= r_in_rp + PTR_W'(1);
      if (w_out_push) r_out_wp <= r_out_wp + PTR_W'(1);
      if (w_out_pop)  r_out_rp <= r_out_rp + PTR_W'(1);

      case ({w_in_push, w_in_pop})
        2'b10:   r_in_cnt <= r_in_cnt + CNT_W'(1);
        2'b01:   r_in_cnt <= r_in_cnt - CNT_W'(1);
        default: r_in_cnt <= r_in_cnt;
      endcase
      case ({w_out_push, w_out_pop})
        2'b10:   r_out_cnt <= r_out_cnt + CNT_W'(1);
        2'b01:   r_out_cnt <= r_out_cnt - CNT_W'(1);
        default: r_out_cnt <= r_out_cnt;
      endcase

      if (w_rd_edge) r_cpu_in <= w_in_empty ? '0 : r_in_mem[r_in_rp];
      if (w_wr_edge) r_last_out <= cpu_out;

      // A new error in the same cycle as clear_flags keeps the flag set.
      if (w_rd_edge && w_in_empty) r_in_uf <= 1'b1;
      else if (clear_flags)        r_in_uf <= 1'b0;
      if (w_wr_edge && w_out_full) r_out_of <= 1'b1;
      else if (clear_flags)        r_out_of <= 1'b0;
    end
  end

  assign cpu_in         = r_cpu_in;
  assign last_out       = r_last_out;
  assign host_in_ready  = ~w_in_full;
  assign host_out_data  = r_out_mem[r_out_rp];
  assign host_out_valid = ~w_out_empty;
  assign in_count       = r_in_cnt;
  assign out_count      = r_out_cnt;
  assign in_underflow   = r_in_uf;
  assign out_overflow   = r_out_of;

endmodule

// File: tb/tb_cpu_io_port.sv
// Bench for cpu_io_port: queue-based reference model updated on each clock edge,
// with a negedge monitor comparing DUT outputs against model state and scoreboards.
module tb_cpu_io_port;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] cpu_in;
  logic              cpu_in_en;
  logic [DATA_W-1:0] cpu_out;
  logic              cpu_out_en;
  logic [DATA_W-1:0] host_in_data;
  logic              host_in_valid;
  logic              host_in_ready;
  logic [DATA_W-1:0] host_out_data;
  logic              host_out_valid;
  logic              host_out_ready;
  logic [CNT_W-1:0]  in_count;
  logic [CNT_W-1:0]  out_count;
  logic              in_underflow;
  logic              out_overflow;
  logic              clear_flags;
  logic [DATA_W-1:0] last_out;

  cpu_io_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_in(cpu_in), .cpu_in_en(cpu_in_en),
    .cpu_out(cpu_out), .cpu_out_en(cpu_out_en),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
    .host_out_data(host_out_data), .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
    .in_count(in_count), .out_count(out_count),
    .in_underflow(in_underflow), .out_overflow(out_overflow),
    .clear_flags(clear_flags), .last_out(last_out)
  );

  always #5 clk = ~clk;

  // Reference model state
  byte unsigned in_q[$];
  byte unsigned out_q[$];
  byte unsigned sb_rd[$];
  byte unsigned sb_out[$];
  bit  prev_ien = 1'b1, prev_oen = 1'b1;
  int  exp_cpu_in = 0, exp_last = 0;
  bit  exp_uf = 1'b0, exp_of = 1'b0;
  bit  mon_en = 1'b0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: inputs are stable around the posedge, so reading them here matches the DUT.
  always @(posedge clk) begin
    if (rst) begin
      in_q.delete(); out_q.delete(); sb_rd.delete(); sb_out.delete();
      prev_ien = 1'b1; prev_oen = 1'b1;
      exp_cpu_in = 0; exp_last = 0; exp_uf = 1'b0; exp_of = 1'b0;
      mon_en = 1'b1;
    end else begin
      int in_sz, out_sz;
      bit rd, wr;
      in_sz  = in_q.size();
      out_sz = out_q.size();
      rd = cpu_in_en && !prev_ien;
      wr = cpu_out_en && !prev_oen;
      prev_ien = cpu_in_en;
      prev_oen = cpu_out_en;

      if (rd) begin
        if (in_sz > 0) exp_cpu_in = in_q.pop_front();
        else           exp_cpu_in = 0;
        sb_rd.push_back(byte'(exp_cpu_in));
      end
      if (host_in_valid && in_sz < DEPTH) in_q.push_back(host_in_data);

      if (host_out_ready && out_sz > 0) void'(out_q.pop_front());
      if (wr) begin
        exp_last = cpu_out;
        if (out_sz < DEPTH) begin
          out_q.push_back(cpu_out);
          sb_out.push_back(cpu_out);
        end
      end

      if (rd && in_sz == 0)          exp_uf = 1'b1;
      else if (clear_flags)          exp_uf = 1'b0;
      if (wr && out_sz == DEPTH)     exp_of = 1'b1;
      else if (clear_flags)          exp_of = 1'b0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb_rd.size() > 0) chk("cpu_in_after_read", int'(cpu_in), int'(sb_rd.pop_front()));
      chk("cpu_in_hold", int'(cpu_in), exp_cpu_in);
      chk("in_count", int'(in_count), in_q.size());
      chk("out_count", int'(out_count), out_q.size());
      chk("host_in_ready", int'(host_in_ready), int'(in_q.size() != DEPTH));
      chk("host_out_valid", int'(host_out_valid), int'(out_q.size() != 0));
      chk("in_underflow", int'(in_underflow), int'(exp_uf));
      chk("out_overflow", int'(out_overflow), int'(exp_of));
      chk("last_out", int'(last_out), exp_last);
      if (host_out_valid && host_out_ready) begin
        if (sb_out.size() == 0) chk("host_out_unexpected", 1, 0);
        else                    chk("host_out_data", int'(host_out_data), int'(sb_out.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] b);
    host_in_valid = 1'b1;
    host_in_data  = b;
    tick();
    host_in_valid = 1'b0;
  endtask

  task automatic rand_seg(input int cycles, input int pv, input int pr);
    for (int i = 0; i < cycles; i++) begin
      host_in_valid  = ($urandom_range(0, 99) < pv);
      host_in_data   = DATA_W'($urandom);
      host_out_ready = ($urandom_range(0, 99) < pr);
      cpu_out        = DATA_W'($urandom);
      if ($urandom_range(0, 2) == 0) cpu_in_en  = ~cpu_in_en;
      if ($urandom_range(0, 2) == 0) cpu_out_en = ~cpu_out_en;
      clear_flags    = ($urandom_range(0, 15) == 0);
      rst            = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    clear_flags = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cpu_in_en = 1'b0; cpu_out = '0; cpu_out_en = 1'b0;
    host_in_data = '0; host_in_valid = 1'b0; host_out_ready = 1'b0; clear_flags = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Three pushes, three separated single-cycle reads
    push(8'h11); push(8'h22); push(8'h33);
    repeat (3) begin
      cpu_in_en = 1'b1; tick(); cpu_in_en = 1'b0; tick();
    end
    tick();

    // Held strobe gives exactly one pop
    push(8'hA5); push(8'h5A);
    cpu_in_en = 1'b1; repeat (5) tick(); cpu_in_en = 1'b0; tick();
    cpu_in_en = 1'b1; tick(); cpu_in_en = 1'b0; tick();

    // Underflow, clear, clear colliding with a new underflow
    cpu_in_en = 1'b1; tick(); cpu_in_en = 1'b0; tick();
    clear_flags = 1'b1; tick(); clear_flags = 1'b0; tick();
    cpu_in_en = 1'b1; clear_flags = 1'b1; tick(); cpu_in_en = 1'b0; clear_flags = 1'b0; tick();
    clear_flags = 1'b1; tick(); clear_flags = 1'b0; tick();

    // Nine writes into a depth-8 output FIFO, then drain
    host_out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      cpu_out = DATA_W'(i); cpu_out_en = 1'b1; tick(); cpu_out_en = 1'b0; tick();
    end
    host_out_ready = 1'b1; repeat (10) tick(); host_out_ready = 1'b0;
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;

    // Full input FIFO refuses a push even alongside a pop
    for (int i = 0; i < DEPTH; i++) push(DATA_W'($urandom));
    host_in_valid = 1'b1; host_in_data = 8'hEE; cpu_in_en = 1'b1; tick();
    host_in_valid = 1'b0; cpu_in_en = 1'b0; tick();

    // Sustained traffic to wrap the pointers
    for (int i = 0; i < 20; i++) begin
      host_in_valid = 1'b1; host_in_data = DATA_W'($urandom); cpu_in_en = 1'b1; tick();
      host_in_valid = 1'b0; cpu_in_en = 1'b0; tick();
    end
    for (int i = 0; i < 12; i++) begin
      cpu_out = DATA_W'($urandom); cpu_out_en = 1'b1; host_out_ready = i[0]; tick();
      cpu_out_en = 1'b0; tick();
    end

    rand_seg(400, 80, 20);
    rand_seg(400, 20, 80);
    rand_seg(400, 50, 50);
    rand_seg(400, 90, 90);

    // Reset mid-stream with the read strobe held across release
    host_in_valid = 1'b0; host_out_ready = 1'b0; cpu_in_en = 1'b0; cpu_out_en = 1'b0; tick();
    push(8'h41); push(8'h42); push(8'h43);
    cpu_out = 8'h77; cpu_out_en = 1'b1; tick(); cpu_out_en = 1'b0; tick();
    cpu_in_en = 1'b1; tick();
    rst = 1'b1; repeat (2) tick(); rst = 1'b0;
    push(8'h99);
    repeat (3) tick();
    cpu_in_en = 1'b0; tick();
    cpu_in_en = 1'b1; tick(); cpu_in_en = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_io_port.md
Name: cpu_io_port

Overview:
- Peripheral-side endpoint for the CPU's byte I/O channel: the I / IEnable input path and the O / OEnable output path.
- Buffers host-supplied bytes in an input FIFO and serves one byte per CPU read strobe.
- Captures one byte per CPU write strobe into an output FIFO, which the host drains over a valid/ready handshake.
- Sits beside the CPU inside the top-level computer. Also drives sticky error flags and a last-written-byte register for the monitor display.

Parameters:
DATA_W, 8, byte width of all data paths
DEPTH, 8, entries per FIFO; must be a power of two, at least 2
CNT_W, $clog2(DEPTH)+1, width of the occupancy counters

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
cpu_in  output  DATA_W  byte presented to the CPU I input
cpu_in_en  input  1  CPU IEnable (read strobe, level)
cpu_out  input  DATA_W  CPU O output
cpu_out_en  input  1  CPU OEnable (write strobe, level)
host_in_data  input  DATA_W  byte pushed by host
host_in_valid  input  1  host push request
host_in_ready  output  1  input FIFO not full
host_out_data  output  DATA_W  head of output FIFO
host_out_valid  output  1  output FIFO not empty
host_out_ready  input  1  host accepts head byte
in_count  output  CNT_W  input FIFO occupancy
out_count  output  CNT_W  output FIFO occupancy
in_underflow  output  1  sticky: CPU read while input FIFO empty
out_overflow  output  1  sticky: CPU write while output FIFO full
clear_flags  input  1  clears both sticky flags
last_out  output  DATA_W  last byte the CPU wrote (dropped writes included)

Behaviour:
- Reset (rst=1 at posedge clk): both FIFOs empty, pointers 0, counts 0, cpu_in=0, last_out=0, flags 0. Edge-detect history registers reset to 1, so a strobe held high across reset release does NOT trigger an access. Reset mid-operation discards all buffered bytes.
- Strobe detection: an access is the rising edge of the strobe, i.e. strobe=1 while the registered previous value=0. A strobe held high for N cycles is exactly one access.
- CPU read (cpu_in_en rising edge):
  - Input FIFO non-empty: cpu_in <= head and the FIFO pops. cpu_in is valid 1 cycle after the edge and holds until the next read.
  - Input FIFO empty: cpu_in <= 0 and in_underflow <= 1.
- Host push: the transfer occurs when host_in_valid && host_in_ready. host_in_ready = !in_full, computed from registered state only. A full FIFO refuses a push even if a CPU pop occurs in the same cycle.
- CPU write (cpu_out_en rising edge):
  - Always: last_out <= cpu_out.
  - Output FIFO not full: push cpu_out.
  - Output FIFO full: byte dropped and out_overflow <= 1.
- Host drain: host_out_data = head, combinational from the RAM/read pointer. host_out_valid = !out_empty. A pop occurs when host_out_valid && host_out_ready.
- Full/empty decisions use pre-cycle state. Simultaneous events in one cycle:
  - Empty input FIFO, host push + CPU read: underflow, cpu_in=0, and the pushed byte is stored.
  - Full output FIFO, host pop + CPU write: write dropped, overflow set, pop proceeds.
  - Non-boundary push + pop on the same FIFO: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts range 0..DEPTH. full = (count==DEPTH); empty = (count==0).
- Flags: clear_flags clears both flags. If a set condition occurs in the same cycle, set wins. rst overrides everything.
- Latency: host push to visible on cpu_in is at least 2 cycles (push cycle, then read edge, then cpu_in updates). CPU write edge to host_out_valid is 1 cycle.
- Width rule: all data DATA_W bits, no sign or extension logic. Counts never exceed DEPTH.

Test Plan:
- Reset, push 0x11, 0x22, 0x33; three single-cycle read strobes, each separated by a low cycle -> cpu_in = 0x11, 0x22, 0x33, each 1 cycle after its edge; in_count 3->0; no underflow.
- Hold cpu_in_en high 5 cycles with FIFO holding 0xA5, 0x5A -> exactly one pop: cpu_in=0xA5, in_count=1.
- Read strobe on empty input FIFO -> cpu_in=0x00, in_underflow=1. Pulse clear_flags -> 0. Clear and underflow in the same cycle -> stays 1.
- With host_out_ready=0, perform 9 write strobes of 0x01..0x09 (DEPTH=8) -> out_count=8, out_overflow=1, last_out=0x09. Then drain -> host sees 0x01..0x08 in order.
- Fill input FIFO to 8, then in one cycle assert host_in_valid with a read edge -> host_in_ready=0 so no push; in_count=7 afterwards. Repeat with 16+ transfers to confirm pointer wrap keeps order.
- Assert rst mid-stream with both FIFOs partly full and cpu_in_en held high -> counts 0, outputs 0, flags 0. No read access after rst deasserts until cpu_in_en goes low then high.
